// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: forward selects,
// FSM states and the pipeline-control bundle.
package hazard_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_bubble;
  } pipe_ctrl_t;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: register-stage
// observations in, enables/bubbles/forward selects out.
interface hazard_forward_ctrl_if #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned STALL_CNT_W = 16
);
  logic [NUM_SRC*REG_AW-1:0] in_ifid_rs;
  logic [NUM_SRC-1:0]        in_ifid_src_used;
  logic [NUM_SRC*REG_AW-1:0] in_idex_rs;
  logic [NUM_SRC-1:0]        in_idex_src_used;
  logic [REG_AW-1:0]         in_idex_rd;
  logic                      in_idex_memread;
  logic                      in_idex_muldiv;
  logic                      in_exmem_regwrite;
  logic [REG_AW-1:0]         in_exmem_rd;
  logic                      in_memwb_regwrite;
  logic [REG_AW-1:0]         in_memwb_rd;
  logic                      in_branch_taken;

  logic [2*NUM_SRC-1:0]      out_fwd_sel;
  logic                      out_pc_en;
  logic                      out_ifid_en;
  logic                      out_ifid_flush;
  logic                      out_idex_en;
  logic                      out_idex_bubble;
  logic                      out_exmem_bubble;
  logic [STALL_CNT_W-1:0]    out_stall_count;

  modport master (
    output in_ifid_rs, in_ifid_src_used, in_idex_rs, in_idex_src_used,
           in_idex_rd, in_idex_memread, in_idex_muldiv, in_exmem_regwrite,
           in_exmem_rd, in_memwb_regwrite, in_memwb_rd, in_branch_taken,
    input  out_fwd_sel, out_pc_en, out_ifid_en, out_ifid_flush, out_idex_en,
           out_idex_bubble, out_exmem_bubble, out_stall_count
  );

  modport slave (
    input  in_ifid_rs, in_ifid_src_used, in_idex_rs, in_idex_src_used,
           in_idex_rd, in_idex_memread, in_idex_muldiv, in_exmem_regwrite,
           in_exmem_rd, in_memwb_regwrite, in_memwb_rd, in_branch_taken,
    output out_fwd_sel, out_pc_en, out_ifid_en, out_ifid_flush, out_idex_en,
           out_idex_bubble, out_exmem_bubble, out_stall_count
  );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Per-source ALU operand forward select; the younger EX/MEM result wins over MEM/WB.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_used,
  input  logic              i_exmem_regwrite,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic              i_memwb_regwrite,
  input  logic [REG_AW-1:0] i_memwb_rd,
  output logic [1:0]        o_sel
);

  logic w_rs_live;
  logic w_exmem_hit;
  logic w_memwb_hit;

  // x0 is hardwired zero, so it never takes a forwarded value
  assign w_rs_live   = i_used && (i_rs != '0);
  assign w_exmem_hit = w_rs_live && i_exmem_regwrite && (i_exmem_rd == i_rs);
  assign w_memwb_hit = w_rs_live && i_memwb_regwrite && (i_memwb_rd == i_rs);

  always_comb begin
    o_sel = FWD_REGFILE;
    if (w_exmem_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_memwb_hit) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: operand forwarding, load-use stall,
// multi-cycle MUL/DIV hold, taken-branch flush and a stall-cycle counter.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned MULDIV_LAT  = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  hazard_forward_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W     = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
  localparam int unsigned BUSY_LOAD = (MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0;
  localparam logic [CNT_W-1:0] BUSY_INIT = CNT_W'(BUSY_LOAD);

  hz_state_e               r_state;
  hz_state_e               w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [STALL_CNT_W-1:0]  r_stall_cnt;
  pipe_ctrl_t              w_ctrl;
  logic [2*NUM_SRC-1:0]    w_fwd_sel;
  logic [NUM_SRC-1:0]      w_lu_hit;
  logic                    w_load_use;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    fwd_select #(.REG_AW(REG_AW)) u_fwd (
      .i_rs             (bus.in_idex_rs[gi*REG_AW +: REG_AW]),
      .i_used           (bus.in_idex_src_used[gi]),
      .i_exmem_regwrite (bus.in_exmem_regwrite),
      .i_exmem_rd       (bus.in_exmem_rd),
      .i_memwb_regwrite (bus.in_memwb_regwrite),
      .i_memwb_rd       (bus.in_memwb_rd),
      .o_sel            (w_fwd_sel[gi*2 +: 2])
    );

    assign w_lu_hit[gi] = bus.in_ifid_src_used[gi] &&
                          (bus.in_ifid_rs[gi*REG_AW +: REG_AW] == bus.in_idex_rd);
  end

  // idex_rd of x0 means the load result is discarded, so nothing waits on it
  assign w_load_use = bus.in_idex_memread && (bus.in_idex_rd != '0) && (|w_lu_hit);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_cnt_nxt           = r_cnt;
    w_ctrl              = '0;
    w_ctrl.pc_en        = 1'b1;
    w_ctrl.ifid_en      = 1'b1;
    w_ctrl.idex_en      = 1'b1;
    unique case (r_state)
      ST_RUN: begin
        // a taken branch squashes whatever sits in ID/EX, so its hazards are moot
        if (bus.in_branch_taken) begin
          w_ctrl.ifid_flush  = 1'b1;
          w_ctrl.idex_bubble = 1'b1;
        end else if (bus.in_idex_muldiv && (MULDIV_LAT > 1)) begin
          w_ctrl.pc_en        = 1'b0;
          w_ctrl.ifid_en      = 1'b0;
          w_ctrl.idex_en      = 1'b0;
          w_ctrl.exmem_bubble = 1'b1;
          w_state_nxt         = ST_BUSY;
          w_cnt_nxt           = BUSY_INIT;
        end else if (w_load_use) begin
          w_ctrl.pc_en       = 1'b0;
          w_ctrl.ifid_en     = 1'b0;
          w_ctrl.idex_bubble = 1'b1;
        end
      end
      ST_BUSY: begin
        w_ctrl.pc_en        = 1'b0;
        w_ctrl.ifid_en      = 1'b0;
        w_ctrl.idex_en      = 1'b0;
        w_ctrl.exmem_bubble = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // saturating count of cycles with the PC frozen
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_stall_cnt <= '0;
    end else if (!w_ctrl.pc_en && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign bus.out_fwd_sel      = w_fwd_sel;
  assign bus.out_pc_en        = w_ctrl.pc_en;
  assign bus.out_ifid_en      = w_ctrl.ifid_en;
  assign bus.out_ifid_flush   = w_ctrl.ifid_flush;
  assign bus.out_idex_en      = w_ctrl.idex_en;
  assign bus.out_idex_bubble  = w_ctrl.idex_bubble;
  assign bus.out_exmem_bubble = w_ctrl.exmem_bubble;
  assign bus.out_stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: a cycle-level reference model checked every
// negedge plus directed scenarios with hand-computed expectations.
module tb_hazard_forward_ctrl;
  import hazard_pkg::*;

  localparam int unsigned REG_AW      = 5;
  localparam int unsigned NUM_SRC     = 2;
  localparam int unsigned MULDIV_LAT  = 4;
  localparam int unsigned STALL_CNT_W = 16;
  localparam int          CNT_MAX     = (1 << STALL_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .STALL_CNT_W(STALL_CNT_W)) bus ();

  hazard_forward_ctrl #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MULDIV_LAT(MULDIV_LAT), .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: number of further frozen cycles owed to a MUL/DIV, and stall total
  int hold_left = 0;
  int m_cnt = 0;

  function automatic logic [1:0] m_fwd(input int i);
    logic [REG_AW-1:0] rs;
    rs = bus.in_idex_rs[i*REG_AW +: REG_AW];
    if (!bus.in_idex_src_used[i] || rs == 0) return 2'b00;
    if (bus.in_exmem_regwrite && bus.in_exmem_rd == rs) return 2'b10;
    if (bus.in_memwb_regwrite && bus.in_memwb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_load_use();
    logic [REG_AW-1:0] rs;
    if (!bus.in_idex_memread || bus.in_idex_rd == 0) return 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs = bus.in_ifid_rs[i*REG_AW +: REG_AW];
      if (bus.in_ifid_src_used[i] && rs == bus.in_idex_rd) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(negedge clk) begin : compare
    logic [2*NUM_SRC-1:0] e_fwd;
    bit e_pc, e_ifen, e_flush, e_idexen, e_bub, e_exb;
    int nxt_hold;
    if (!rst_n) begin
      hold_left = 0;
      m_cnt = 0;
    end
    for (int i = 0; i < NUM_SRC; i++) e_fwd[i*2 +: 2] = m_fwd(i);
    e_pc = 1; e_ifen = 1; e_idexen = 1; e_flush = 0; e_bub = 0; e_exb = 0;
    nxt_hold = hold_left;
    if (hold_left > 0) begin
      e_pc = 0; e_ifen = 0; e_idexen = 0; e_exb = 1;
      nxt_hold = hold_left - 1;
    end else if (bus.in_branch_taken) begin
      e_flush = 1; e_bub = 1;
    end else if (bus.in_idex_muldiv && MULDIV_LAT > 1) begin
      e_pc = 0; e_ifen = 0; e_idexen = 0; e_exb = 1;
      nxt_hold = MULDIV_LAT - 1;
    end else if (m_load_use()) begin
      e_pc = 0; e_ifen = 0; e_bub = 1;
    end
    chk("m_fwd_sel", 32'(bus.out_fwd_sel), 32'(e_fwd));
    chk("m_pc_en", 32'(bus.out_pc_en), 32'(e_pc));
    chk("m_ifid_en", 32'(bus.out_ifid_en), 32'(e_ifen));
    chk("m_ifid_flush", 32'(bus.out_ifid_flush), 32'(e_flush));
    chk("m_idex_en", 32'(bus.out_idex_en), 32'(e_idexen));
    chk("m_idex_bubble", 32'(bus.out_idex_bubble), 32'(e_bub));
    chk("m_exmem_bubble", 32'(bus.out_exmem_bubble), 32'(e_exb));
    chk("m_stall_count", 32'(bus.out_stall_count), 32'(m_cnt));
    if (rst_n) begin
      hold_left = nxt_hold;
      if (!e_pc && m_cnt < CNT_MAX) m_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_ifid_rs = '0; bus.in_ifid_src_used = '0;
    bus.in_idex_rs = '0; bus.in_idex_src_used = '0;
    bus.in_idex_rd = '0; bus.in_idex_memread = 1'b0; bus.in_idex_muldiv = 1'b0;
    bus.in_exmem_regwrite = 1'b0; bus.in_exmem_rd = '0;
    bus.in_memwb_regwrite = 1'b0; bus.in_memwb_rd = '0;
    bus.in_branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    clear_inputs();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_stall_count", 32'(bus.out_stall_count), 32'd0);
    chk("reset_pc_en", 32'(bus.out_pc_en), 32'd1);
    step(); step();
    rst_n = 1'b1;

    // Forwarding: EX/MEM priority, unused source, MEM/WB fallback
    step();
    bus.in_exmem_regwrite = 1; bus.in_exmem_rd = 5'd5;
    bus.in_memwb_regwrite = 1; bus.in_memwb_rd = 5'd5;
    bus.in_idex_rs = {5'd5, 5'd5}; bus.in_idex_src_used = 2'b01;
    #1 chk("t1_fwd_src0_only", 32'(bus.out_fwd_sel), 32'h2);
    step();
    bus.in_idex_src_used = 2'b11;
    #1 chk("t1_fwd_both_exmem", 32'(bus.out_fwd_sel), 32'hA);
    step();
    bus.in_exmem_regwrite = 0;
    #1 chk("t1_fwd_both_memwb", 32'(bus.out_fwd_sel), 32'h5);
    step();
    bus.in_exmem_regwrite = 1; bus.in_exmem_rd = 5'd3; bus.in_memwb_rd = 5'd9;
    bus.in_idex_rs = {5'd9, 5'd3};
    #1 chk("t1_fwd_split", 32'(bus.out_fwd_sel), 32'h6);

    // x0 never forwards
    step();
    bus.in_memwb_rd = 5'd0; bus.in_exmem_rd = 5'd0; bus.in_idex_rs = {5'd0, 5'd0};
    #1 chk("t2_fwd_x0", 32'(bus.out_fwd_sel), 32'h0);

    // Load-use single-cycle stall
    do_reset();
    step();
    bus.in_idex_memread = 1; bus.in_idex_rd = 5'd7;
    bus.in_ifid_rs = {5'd7, 5'd3}; bus.in_ifid_src_used = 2'b10;
    #1;
    chk("t3_lu_pc_en", 32'(bus.out_pc_en), 32'd0);
    chk("t3_lu_ifid_en", 32'(bus.out_ifid_en), 32'd0);
    chk("t3_lu_bubble", 32'(bus.out_idex_bubble), 32'd1);
    step();
    bus.in_idex_memread = 0;
    #1;
    chk("t3_after_pc_en", 32'(bus.out_pc_en), 32'd1);
    chk("t3_stall_count", 32'(bus.out_stall_count), 32'd1);
    step();
    bus.in_idex_memread = 1; bus.in_ifid_src_used = 2'b01;
    #1 chk("t3_unused_src", 32'(bus.out_pc_en), 32'd1);
    step();
    bus.in_idex_rd = 5'd0; bus.in_ifid_rs = {5'd0, 5'd0}; bus.in_ifid_src_used = 2'b11;
    #1 chk("t3_lu_x0", 32'(bus.out_pc_en), 32'd1);

    // MUL/DIV hold of MULDIV_LAT cycles; branch ignored while busy
    do_reset();
    step();
    bus.in_idex_muldiv = 1;
    #1;
    chk("t4_c0_pc_en", 32'(bus.out_pc_en), 32'd0);
    chk("t4_c0_exb", 32'(bus.out_exmem_bubble), 32'd1);
    chk("t4_c0_idex_en", 32'(bus.out_idex_en), 32'd0);
    step();
    bus.in_idex_muldiv = 0;
    #1 chk("t4_c1_pc_en", 32'(bus.out_pc_en), 32'd0);
    step();
    bus.in_branch_taken = 1;
    #1;
    chk("t4_c2_no_flush", 32'(bus.out_ifid_flush), 32'd0);
    chk("t4_c2_exb", 32'(bus.out_exmem_bubble), 32'd1);
    step();
    bus.in_branch_taken = 0;
    #1 chk("t4_c3_pc_en", 32'(bus.out_pc_en), 32'd0);
    step();
    #1;
    chk("t4_c4_pc_en", 32'(bus.out_pc_en), 32'd1);
    chk("t4_c4_exb", 32'(bus.out_exmem_bubble), 32'd0);
    chk("t4_stall_count", 32'(bus.out_stall_count), 32'd4);

    // Branch overrides both load-use and muldiv
    do_reset();
    step();
    bus.in_branch_taken = 1; bus.in_idex_muldiv = 1;
    bus.in_idex_memread = 1; bus.in_idex_rd = 5'd7;
    bus.in_ifid_rs = {5'd7, 5'd0}; bus.in_ifid_src_used = 2'b10;
    #1;
    chk("t5_flush", 32'(bus.out_ifid_flush), 32'd1);
    chk("t5_bubble", 32'(bus.out_idex_bubble), 32'd1);
    chk("t5_pc_en", 32'(bus.out_pc_en), 32'd1);
    chk("t5_exb", 32'(bus.out_exmem_bubble), 32'd0);
    step();
    clear_inputs();
    #1;
    chk("t5_stays_run", 32'(bus.out_pc_en), 32'd1);
    chk("t5_stall_count", 32'(bus.out_stall_count), 32'd0);

    // Reset in the middle of BUSY
    do_reset();
    step();
    bus.in_idex_muldiv = 1;
    step();
    bus.in_idex_muldiv = 0;
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pc_en", 32'(bus.out_pc_en), 32'd1);
    chk("t6_rst_exb", 32'(bus.out_exmem_bubble), 32'd0);
    chk("t6_rst_stall_count", 32'(bus.out_stall_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    #1 chk("t6_no_hold", 32'(bus.out_pc_en), 32'd1);

    // Saturation of the stall counter
    step();
    bus.in_idex_muldiv = 1;
    repeat (65539 + 2) step();
    bus.in_idex_muldiv = 0;
    repeat (4) step();
    #1;
    chk("t6_sat_count", 32'(bus.out_stall_count), 32'hFFFF);
    chk("t6_sat_pc_en", 32'(bus.out_pc_en), 32'd1);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Parametrised hazard and forwarding controller for the pipelined RISC-V core. It generalises operand forwarding to NUM_SRC source operands, each with a per-source "used" qualifier instead of opcode decoding. It adds load-use stall detection, a multi-cycle MUL/DIV hold state machine, taken-branch flush control and a saturating stall-cycle counter. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and drives their enables and bubbles, plus the ALU operand muxes.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, number of source operands per instruction
MULDIV_LAT, 4, total EX-stage cycles occupied by a MUL/DIV op (>=1)
STALL_CNT_W, 16, width of stall performance counter

Ports:
in_clk  in  1  clock
in_rst_n  in  1  reset
in_ifid_rs  in  NUM_SRC*REG_AW  IF/ID source regs, source i at [i*REG_AW +: REG_AW]
in_ifid_src_used  in  NUM_SRC  IF/ID source i is read
in_idex_rs  in  NUM_SRC*REG_AW  ID/EX source regs
in_idex_src_used  in  NUM_SRC  ID/EX source i is read
in_idex_rd  in  REG_AW  ID/EX destination
in_idex_memread  in  1  ID/EX is a load
in_idex_muldiv  in  1  ID/EX is a multi-cycle MUL/DIV
in_exmem_regwrite  in  1  EX/MEM writes rd
in_exmem_rd  in  REG_AW  EX/MEM destination
in_memwb_regwrite  in  1  MEM/WB writes rd
in_memwb_rd  in  REG_AW  MEM/WB destination
in_branch_taken  in  1  branch/jump resolved taken in EX
out_fwd_sel  out  2*NUM_SRC  per-source mux select, source i at [2*i +: 2]; 00 regfile, 01 MEM/WB, 10 EX/MEM
out_pc_en  out  1  PC update enable
out_ifid_en  out  1  IF/ID load enable
out_ifid_flush  out  1  IF/ID clear to NOP
out_idex_en  out  1  ID/EX load enable
out_idex_bubble  out  1  ID/EX load NOP
out_exmem_bubble  out  1  EX/MEM load NOP
out_stall_count  out  STALL_CNT_W  cycles with out_pc_en=0

Behaviour:
- Clocking: one clock, in_clk. Reset in_rst_n is asynchronous, active-low. Reset puts the FSM in RUN, the busy counter at 0 and out_stall_count at 0.
- Outputs in RUN with no hazard: pc/ifid/idex_en=1, flush/bubbles=0.
- Forwarding is combinational and evaluated independently per source i.
  - 10 if in_idex_src_used[i], exmem_regwrite, exmem_rd!=0 and exmem_rd==rs_i.
  - Else 01 if the same conditions hold for MEM/WB.
  - Else 00. EX/MEM always wins when both match.
- FSM states: RUN, BUSY.
- RUN priority 1, branch: in_branch_taken -> ifid_flush=1, idex_bubble=1, pc_en=1. This overrides load-use and muldiv, since the muldiv/load in ID/EX is on the taken path.
- RUN priority 2, muldiv: in_idex_muldiv and MULDIV_LAT>1 -> pc_en=ifid_en=idex_en=0, exmem_bubble=1. Next state BUSY with counter=MULDIV_LAT-2.
- RUN priority 3, load-use: in_idex_memread, idex_rd!=0, and some i with ifid_src_used[i] and ifid_rs_i==idex_rd -> pc_en=ifid_en=0, idex_bubble=1. This is a single cycle; the state stays RUN.
- BUSY: pc_en=ifid_en=idex_en=0, exmem_bubble=1, in_branch_taken ignored.
  - Counter decrements each cycle; at counter==0, next state is RUN.
  - The op occupies EX exactly MULDIV_LAT cycles. On the cycle after BUSY exits, EX/MEM captures the result.
- MULDIV_LAT=1: muldiv is treated as a normal op and BUSY is never entered.
- out_stall_count: registered, +1 on each cycle where out_pc_en=0, saturates at all-ones.
- Reset asserted mid-BUSY: immediate return to RUN, counter 0, no hold.
- Source register x0 never matches for forwarding or load-use.

Decomposition:
- Package hazard_pkg: FWD_REGFILE=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10; FSM state encoding RUN/BUSY.
- Sub-module fwd_select: one instance per source via generate. Inputs are rs, used and both rd/regwrite pairs; output is the 2-bit select.

Test Plan:
1. exmem_regwrite=1, exmem_rd=5; memwb_regwrite=1, memwb_rd=5; idex_rs0=5, rs1=5, src_used=2'b01 -> fwd_sel=4'b0010 (src0 EX/MEM, src1 unused 00).
2. memwb_rd=0, memwb_regwrite=1, idex_rs0=0 -> fwd_sel[1:0]=00. exmem_rd=0 likewise -> 00.
3. Load-use: idex_memread=1, idex_rd=7, ifid_rs1=7, used=2'b10 -> one cycle pc_en=0, ifid_en=0, idex_bubble=1, then normal; stall_count=1.
4. MULDIV_LAT=4, in_idex_muldiv=1 for one cycle -> pc_en=0 for exactly 4 cycles (RUN + 3 BUSY), exmem_bubble=1 those 4 cycles; stall_count=4. A branch_taken pulse during BUSY -> no flush.
5. branch_taken=1 together with load-use and muldiv -> ifid_flush=1, idex_bubble=1, pc_en=1, FSM stays RUN.
6. Assert in_rst_n=0 in the 2nd BUSY cycle -> outputs immediately back to RUN defaults, stall_count=0; force 2^16+3 stall cycles -> stall_count holds 16'hFFFF.
